// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: immediate format selects and datapath width.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_U = 3'd0,
    IMM_J = 3'd1,
    IMM_I = 3'd2,
    IMM_B = 3'd3,
    IMM_S = 3'd4
  } immsel_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate extractor: pure bit selection and sign replication.
module imm_decode
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] inst_i,
  input  logic [2:0]      sel_i,
  output logic [XLEN-1:0] imm_o
);

  logic sign;
  // Opcode bits never contribute to any immediate.
  logic unused_opcode;

  assign sign          = inst_i[31];
  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    imm_o = '0;
    case (sel_i)
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{sign}}, sign, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      IMM_I: imm_o = {{20{sign}}, inst_i[31:20]};
      IMM_B: imm_o = {{19{sign}}, sign, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_S: imm_o = {{20{sign}}, inst_i[31:25], inst_i[11:7]};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Registered immediate generator: decodes on in_valid and presents the result one cycle later.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_imm,
  input  logic [2:0]      immsel_g,
  input  logic            in_valid,
  output logic [XLEN-1:0] immgen_out,
  output logic            out_valid
);

  logic [XLEN-1:0] decoded;
  logic [XLEN-1:0] imm_d, imm_q;
  logic            valid_d, valid_q;

  imm_decode u_decode (
    .inst_i (inst_imm),
    .sel_i  (immsel_g),
    .imm_o  (decoded)
  );

  // The immediate holds across idle cycles; only the strobe drops.
  always_comb begin
    imm_d   = in_valid ? decoded : imm_q;
    valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign immgen_out = imm_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed format vectors, control/reset cases, random vs. reference model.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_imm;
  logic [2:0]  immsel_g;
  logic        in_valid;
  logic [31:0] immgen_out;
  logic        out_valid;

  int pass_cnt;
  int total_cnt;

  imm_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_imm   (inst_imm),
    .immsel_g   (immsel_g),
    .in_valid   (in_valid),
    .immgen_out (immgen_out),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: immediates assembled from instruction fields with shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [2:0] sel, input logic [31:0] inst);
    logic signed [31:0] si;
    logic [31:0] ones;
    si   = inst;
    ones = 32'(si >>> 31);
    case (sel)
      3'd0: ref_imm = inst & 32'hFFFF_F000;
      3'd1: ref_imm = (ones << 20) | (((inst >> 12) & 32'hFF) << 12)
                    | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
      3'd2: ref_imm = 32'(si >>> 20);
      3'd3: ref_imm = (ones << 12) | (((inst >> 7) & 32'h1) << 11)
                    | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      3'd4: ref_imm = (32'(si >>> 25) << 5) | ((inst >> 7) & 32'h1F);
      default: ref_imm = 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Present one valid input and check the registered result just after the capturing edge.
  task automatic apply(input string tag, input logic [2:0] sel, input logic [31:0] inst,
                       input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    immsel_g = sel;
    inst_imm = inst;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
    check(tag, immgen_out, exp);
    $display("txn %s sel=%0d inst=%08h out=%08h valid=%0b", tag, sel, inst, immgen_out, out_valid);
  endtask

  task automatic idle(input string tag, input logic [31:0] exp_hold);
    @(negedge clk);
    in_valid = 1'b0;
    inst_imm = 32'hFFFF_FFFF;
    immsel_g = 3'd2;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_hold"}, immgen_out, exp_hold);
    $display("txn %s idle out=%08h valid=%0b", tag, immgen_out, out_valid);
  endtask

  initial begin
    logic [2:0]  rsel;
    logic [31:0] rinst;
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst_imm  = 32'h0;
    immsel_g  = 3'd0;

    #2;
    check("reset_out", immgen_out, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    #5 rst_n = 1'b1;

    @(posedge clk);
    #1;
    check("post_reset_valid", {31'b0, out_valid}, 32'h0);

    apply("u_low",   3'd0, 32'h0000_1000, 32'h0000_1000);
    idle ("u_pulse", 32'h0000_1000);
    apply("u_high",  3'd0, 32'h8000_0000, 32'h8000_0000);
    apply("j_pos",   3'd1, 32'h7FE0_0000, 32'h0000_07FE);
    apply("j_neg",   3'd1, 32'hFFE0_0000, 32'hFFF0_07FE);
    apply("i_pos",   3'd2, 32'h7F0F_F000, 32'h0000_07F0);
    apply("i_neg",   3'd2, 32'hFF0F_F000, 32'hFFFF_FFF0);
    apply("b_bit7",  3'd3, 32'h0000_0080, 32'h0000_0800);
    apply("b_neg",   3'd3, 32'h8000_0080, 32'hFFFF_F800);
    apply("s_pos",   3'd4, 32'h7E00_0F80, 32'h0000_07FF);
    apply("s_neg",   3'd4, 32'hFE00_0F80, 32'hFFFF_FFFF);
    apply("sel5",    3'd5, 32'hFFFF_FFFF, 32'h0000_0000);
    apply("sel6",    3'd6, 32'hFFFF_FFFF, 32'h0000_0000);
    apply("sel7",    3'd7, 32'hFFFF_FFFF, 32'h0000_0000);
    apply("i_set",   3'd2, 32'h1230_0000, 32'h0000_0123);
    idle ("hold1",   32'h0000_0123);
    idle ("hold2",   32'h0000_0123);

    // Asynchronous reset between edges, with a pending input that must be discarded.
    @(negedge clk);
    in_valid = 1'b1;
    immsel_g = 3'd2;
    inst_imm = 32'hFFF0_0000;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", immgen_out, 32'h0);
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_out", immgen_out, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_valid", {31'b0, out_valid}, 32'h0);
    check("rst_release_out", immgen_out, 32'h0);

    // Back-to-back random transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      rsel  = 3'($urandom_range(0, 7));
      rinst = $urandom;
      apply($sformatf("rand%0d", n), rsel, rinst, ref_imm(rsel, rinst));
    end
    idle("final", ref_imm(rsel, rinst));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
